// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive channel: parity encodings,
// receiver FSM states and small helper functions.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Clock divider for the oversampling tick, rounded to nearest, never below 1.
  function automatic int calc_div(input longint clk_hz, input longint baud, input longint ovs);
    longint den;
    longint q;
    den = baud * ovs;
    q   = (clk_hz + den / 2) / den;
    if (q < 1) q = 1;
    return int'(q);
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A write while full is accepted only when a read happens in the same cycle.
// While empty, rd_data_o holds the last head value that was presented.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   full_o,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] hold_q;
  logic             rd_ok;
  logic             wr_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign rd_ok     = rd_en_i && !empty_o;
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign rd_data_o = empty_o ? hold_q : mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Occupancy next state from the accepted write/read pair.
  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array; contents are only observed while not empty.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, count and the head-hold register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (!empty_o) hold_q <= mem_q[rd_ptr_q];
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled majority-vote bit decisions, optional
// parity, 1 or 2 stop bits, error pulses and a FWFT receive FIFO.
//
// Receive handshake: vld_rx is high whenever the FIFO holds a word and d_rx
// is that word; a word is consumed on every clock edge where vld_rx and
// rdy_rx are both high. rdy_rx is ignored while vld_rx is low, and d_rx
// keeps the last head value until a new word arrives.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic [DATA_BITS-1:0]   d_rx,
  output logic                   vld_rx,
  input  logic                   rdy_rx,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_parity,
  output logic                   err_frame,
  output logic                   err_overrun,
  output logic [2:0]             dbg_state
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVS);
  localparam int DIV_W = $clog2(DIV) + 1;
  localparam int SC_W  = $clog2(OVS);
  localparam logic [SC_W-1:0] SC_LO  = SC_W'(OVS / 2 - 1);
  localparam logic [SC_W-1:0] SC_MID = SC_W'(OVS / 2);
  localparam logic [SC_W-1:0] SC_HI  = SC_W'(OVS / 2 + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(OVS - 1);

  rx_state_e            state_q;
  logic                 rxd_meta_q;
  logic                 rxd_s_q;
  logic [DIV_W-1:0]     div_q;
  logic [SC_W-1:0]      sc_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           samp_q;
  logic                 par_bad_q;
  logic                 push_q;
  logic                 err_parity_q;
  logic                 err_frame_q;

  logic start_det;
  logic tick;
  logic decide;
  logic wrap;
  logic bit_val;
  logic exp_par;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign start_det = (state_q == ST_IDLE) && !rxd_s_q;
  assign tick      = (div_q == DIV_W'(DIV - 1));
  assign decide    = tick && (sc_q == SC_HI);
  assign wrap      = tick && (sc_q == SC_MAX);
  assign bit_val   = maj3(samp_q[0], samp_q[1], rxd_s_q);
  assign exp_par   = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

  // Two-flop synchroniser for the asynchronous line, idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Oversampling tick: free-running divider, realigned at start-bit detection.
  always_ff @(posedge clk) begin
    if (rst || start_det || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Receiver FSM: sample counter, majority sampling, shifting and frame checks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sc_q         <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      samp_q       <= 2'b11;
      par_bad_q    <= 1'b0;
      push_q       <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      if (tick && state_q != ST_IDLE && state_q != ST_BREAK) begin
        sc_q <= (sc_q == SC_MAX) ? '0 : sc_q + SC_W'(1);
        if (sc_q == SC_LO)  samp_q[0] <= rxd_s_q;
        if (sc_q == SC_MID) samp_q[1] <= rxd_s_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s_q) begin
            sc_q      <= '0;
            par_bad_q <= 1'b0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (decide && bit_val) begin
            state_q <= ST_IDLE;
          end else if (wrap) begin
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (decide) par_bad_q <= (bit_val != exp_par);
          if (wrap) begin
            bit_cnt_q <= '0;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // The last stop bit finishes at its decision point so that a
          // following start edge is never missed.
          if (decide) begin
            if (!bit_val) begin
              err_frame_q <= 1'b1;
              state_q     <= ST_BREAK;
            end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
              if (par_bad_q) err_parity_q <= 1'b1;
              else           push_q       <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (wrap) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        ST_BREAK: begin
          if (rxd_s_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pop = vld_rx && rdy_rx;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (push_q),
    .wr_data_i (shift_q),
    .full_o    (fifo_full),
    .rd_en_i   (rdy_rx),
    .rd_data_o (d_rx),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  assign vld_rx      = !fifo_empty;
  assign err_parity  = err_parity_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = push_q && fifo_full && !pop;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance,
// both with a 4-entry FIFO and a 64-cycle bit time.
module tb_uart_rx_fifo;

  localparam int BIT_T = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_n = 1'b1;
  logic       rxd_e = 1'b1;
  logic       rdy_n = 1'b0;
  logic       rdy_e = 1'b0;
  logic [7:0] d_rx_n, d_rx_e;
  logic       vld_n, vld_e;
  logic [2:0] count_n, count_e;
  logic       epar_n, efrm_n, eovr_n;
  logic       epar_e, efrm_e, eovr_e;
  logic [2:0] dbg_n, dbg_e;

  int n_checks = 0;
  int n_fail   = 0;
  int pops_n = 0, pops_e = 0;
  int par_cnt_n = 0, frm_cnt_n = 0, ovr_cnt_n = 0;
  int par_cnt_e = 0, frm_cnt_e = 0, ovr_cnt_e = 0;
  logic [7:0] exp_q_n [$];
  logic [7:0] exp_q_e [$];

  // Clock / reset
  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ(7_372_800), .BAUD(115200), .OVS(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .DEPTH(4)
  ) u_dut_n (
    .clk(clk), .rst(rst), .rxd(rxd_n), .d_rx(d_rx_n), .vld_rx(vld_n),
    .rdy_rx(rdy_n), .count(count_n), .err_parity(epar_n), .err_frame(efrm_n),
    .err_overrun(eovr_n), .dbg_state(dbg_n)
  );

  uart_rx_fifo #(
    .CLK_HZ(7_372_800), .BAUD(115200), .OVS(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .DEPTH(4)
  ) u_dut_e (
    .clk(clk), .rst(rst), .rxd(rxd_e), .d_rx(d_rx_e), .vld_rx(vld_e),
    .rdy_rx(rdy_e), .count(count_e), .err_parity(epar_e), .err_frame(efrm_e),
    .err_overrun(eovr_e), .dbg_state(dbg_e)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compares every consumed word and tallies error pulses.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (vld_n && rdy_n) begin
        pops_n++;
        if (exp_q_n.size() == 0) check_eq("pop_n_unexpected", 32'(exp_q_n.size()), 1);
        else check_eq("pop_n_data", 32'(d_rx_n), 32'(exp_q_n.pop_front()));
      end
      if (vld_e && rdy_e) begin
        pops_e++;
        if (exp_q_e.size() == 0) check_eq("pop_e_unexpected", 32'(exp_q_e.size()), 1);
        else check_eq("pop_e_data", 32'(d_rx_e), 32'(exp_q_e.pop_front()));
      end
      if (epar_n) par_cnt_n++;
      if (efrm_n) frm_cnt_n++;
      if (eovr_n) ovr_cnt_n++;
      if (epar_e) par_cnt_e++;
      if (efrm_e) frm_cnt_e++;
      if (eovr_e) ovr_cnt_e++;
    end
  end

  // Driver tasks
  task automatic set_rxd(input int sel, input logic v);
    if (sel == 0) rxd_n = v;
    else          rxd_e = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit time; with glitch set, the middle-sample window is inverted.
  task automatic drive_bit(input int sel, input logic v, input bit glitch);
    for (int c = 0; c < BIT_T; c++) begin
      set_rxd(sel, (glitch && c >= 34 && c <= 37) ? ~v : v);
      @(negedge clk);
    end
  endtask

  // par_bit < 0 means no parity bit; stop_bits counts stop bit-times at stop_val.
  task automatic send_frame(input int sel, input logic [7:0] data, input int par_bit,
                            input int stop_bits, input logic stop_val, input bit glitch);
    logic [31:0] pb;
    pb = par_bit;
    drive_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i], glitch);
    if (par_bit >= 0) drive_bit(sel, pb[0], 1'b0);
    for (int i = 0; i < stop_bits; i++) drive_bit(sel, stop_val, 1'b0);
    set_rxd(sel, 1'b1);
  endtask

  task automatic drain_n();
    int budget;
    budget = 0;
    rdy_n = 1'b1;
    while (count_n != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    check_eq("drain_n_count", 32'(count_n), 0);
  endtask

  int p0;

  initial begin
    // Reset values
    idle(4);
    check_eq("rst_vld_n", 32'(vld_n), 0);
    check_eq("rst_count_n", 32'(count_n), 0);
    check_eq("rst_d_rx_n", 32'(d_rx_n), 0);
    check_eq("rst_err_n", 32'({epar_n, efrm_n, eovr_n}), 0);
    check_eq("rst_state_n", 32'(dbg_n), 0);
    check_eq("rst_vld_e", 32'(vld_e), 0);
    rst = 1'b0;
    idle(10);

    // 8N1, 0xA5 with consumer ready
    rdy_n = 1'b1;
    exp_q_n.push_back(8'hA5);
    send_frame(0, 8'hA5, -1, 1, 1'b1, 1'b0);
    idle(BIT_T);
    check_eq("a5_pops", 32'(pops_n), 1);
    check_eq("a5_count", 32'(count_n), 0);
    check_eq("a5_errs", 32'(par_cnt_n + frm_cnt_n + ovr_cnt_n), 0);
    check_eq("a5_d_hold", 32'(d_rx_n), 32'h A5);

    // 8E1: good parity then bad parity
    rdy_e = 1'b1;
    exp_q_e.push_back(8'h03);
    send_frame(1, 8'h03, 0, 1, 1'b1, 1'b0);
    send_frame(1, 8'h03, 1, 1, 1'b1, 1'b0);
    idle(BIT_T);
    check_eq("par_pops", 32'(pops_e), 1);
    check_eq("par_err_parity", 32'(par_cnt_e), 1);
    check_eq("par_err_frame", 32'(frm_cnt_e), 0);
    check_eq("par_count", 32'(count_e), 0);

    // Stop bit held low for 3 bit times, then a good frame
    send_frame(0, 8'h3C, -1, 3, 1'b0, 1'b0);
    idle(2 * BIT_T);
    check_eq("frm_err_frame", 32'(frm_cnt_n), 1);
    check_eq("frm_pops", 32'(pops_n), 1);
    check_eq("frm_err_parity", 32'(par_cnt_n), 0);
    exp_q_n.push_back(8'h55);
    send_frame(0, 8'h55, -1, 1, 1'b1, 1'b0);
    idle(BIT_T);
    check_eq("after_frm_pops", 32'(pops_n), 2);

    // 20-cycle low glitch
    rxd_n = 1'b0;
    idle(20);
    rxd_n = 1'b1;
    idle(4 * BIT_T);
    check_eq("glitch_pops", 32'(pops_n), 2);
    check_eq("glitch_errs", 32'(par_cnt_n + frm_cnt_n + ovr_cnt_n), 1);
    check_eq("glitch_count", 32'(count_n), 0);
    check_eq("glitch_state", 32'(dbg_n), 0);

    // Overrun: five back-to-back frames into a 4-entry FIFO
    rdy_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q_n.push_back(8'(8'h10 + i));
      send_frame(0, 8'(8'h10 + i), -1, 1, 1'b1, 1'b0);
    end
    idle(BIT_T);
    check_eq("ovr_count", 32'(count_n), 4);
    check_eq("ovr_err_overrun", 32'(ovr_cnt_n), 1);
    check_eq("ovr_vld", 32'(vld_n), 1);
    check_eq("ovr_head", 32'(d_rx_n), 32'h10);
    drain_n();
    idle(4);
    check_eq("ovr_drain_pops", 32'(pops_n), 6);

    // Full FIFO with a pop in the push cycle
    rdy_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q_n.push_back(8'(8'h20 + i));
      send_frame(0, 8'(8'h20 + i), -1, 1, 1'b1, 1'b0);
    end
    idle(BIT_T);
    check_eq("full_count", 32'(count_n), 4);
    p0 = pops_n;
    exp_q_n.push_back(8'h24);
    fork
      send_frame(0, 8'h24, -1, 1, 1'b1, 1'b0);
      begin
        idle(619);
        rdy_n = 1'b1;
        @(negedge clk);
        rdy_n = 1'b0;
      end
    join
    idle(BIT_T);
    check_eq("fullpop_count", 32'(count_n), 4);
    check_eq("fullpop_ovr", 32'(ovr_cnt_n), 1);
    check_eq("fullpop_pops", 32'(pops_n - p0), 1);
    check_eq("fullpop_head", 32'(d_rx_n), 32'h21);
    drain_n();

    // Middle sample inverted in every data bit
    exp_q_n.push_back(8'hC3);
    send_frame(0, 8'hC3, -1, 1, 1'b1, 1'b1);
    idle(BIT_T);
    check_eq("maj_pops", 32'(pops_n), 12);
    check_eq("maj_errs", 32'(par_cnt_n + frm_cnt_n + ovr_cnt_n), 2);

    // Reset in the middle of the data bits
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    rst = 1'b1;
    rxd_n = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3 * BIT_T);
    check_eq("rst_mid_count", 32'(count_n), 0);
    check_eq("rst_mid_pops", 32'(pops_n), 12);
    check_eq("rst_mid_errs", 32'(par_cnt_n + frm_cnt_n + ovr_cnt_n), 2);
    exp_q_n.push_back(8'h7E);
    send_frame(0, 8'h7E, -1, 1, 1'b1, 1'b0);
    idle(BIT_T);
    check_eq("after_rst_pops", 32'(pops_n), 13);

    check_eq("exp_q_n_left", 32'(exp_q_n.size()), 0);
    check_eq("exp_q_e_left", 32'(exp_q_e.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
